// File: rtl/mips_cpu_pkg.sv
// Shared types for the multi-cycle multiply/divide unit that feeds the HI/LO register block.
package mips_cpu_pkg;

    localparam int MULDIV_ITER = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_WB   = 2'd3
    } muldiv_state_t;

    function automatic logic op_is_signed(input muldiv_op_t o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

    function automatic logic op_is_div(input muldiv_op_t o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

endpackage

// File: rtl/mips_cpu_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO; drives the HI/LO write bus with one-cycle strobes.
// Signed operations run on magnitudes; signs are applied in a single FIX cycle after the last step.
module mips_cpu_muldiv
    import mips_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = MULDIV_ITER
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  muldiv_op_t            op,
    input  logic [DATA_WIDTH-1:0] rs_val,
    input  logic [DATA_WIDTH-1:0] rt_val,
    input  logic                  cancel,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_hi,
    output logic [DATA_WIDTH-1:0] data_lo,
    output logic                  hi_en,
    output logic                  lo_en
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]         LAST_CNT = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]         CNT_ZERO = {CW{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ZERO_W   = {DATA_WIDTH{1'b0}};
    localparam logic [DATA_WIDTH-1:0] ONES_W   = {DATA_WIDTH{1'b1}};

    muldiv_state_t         state_r;
    muldiv_op_t            op_r;
    logic [CW-1:0]         count_r;
    logic                  sign_a_r;
    logic                  sign_b_r;
    logic [DATA_WIDTH-1:0] mcand_r;
    logic [DATA_WIDTH-1:0] acc_hi_r;
    logic [DATA_WIDTH-1:0] acc_lo_r;
    logic [DATA_WIDTH-1:0] rs_latched_r;
    logic                  busy_r;
    logic                  hi_en_r;
    logic                  lo_en_r;
    logic [DATA_WIDTH-1:0] data_hi_r;
    logic [DATA_WIDTH-1:0] data_lo_r;

    logic                    a_neg_s;
    logic                    b_neg_s;
    logic [DATA_WIDTH-1:0]   a_mag_s;
    logic [DATA_WIDTH-1:0]   b_mag_s;
    logic [DATA_WIDTH:0]     mul_sum_s;
    logic [DATA_WIDTH:0]     div_shift_s;
    logic [DATA_WIDTH:0]     div_diff_s;
    logic [DATA_WIDTH-1:0]   next_hi_s;
    logic [DATA_WIDTH-1:0]   next_lo_s;
    logic                    neg_s;
    logic [2*DATA_WIDTH-1:0] prod_s;
    logic [2*DATA_WIDTH-1:0] prod_fix_s;
    logic [DATA_WIDTH-1:0]   fix_hi_s;
    logic [DATA_WIDTH-1:0]   fix_lo_s;

    // Operand magnitudes and sign flags captured at launch; unsigned magnitudes make 0x80000000 safe.
    always_comb begin
        a_neg_s = op_is_signed(op) & rs_val[DATA_WIDTH-1];
        b_neg_s = op_is_signed(op) & rt_val[DATA_WIDTH-1];
        if (a_neg_s) begin
            a_mag_s = -rs_val;
        end else begin
            a_mag_s = rs_val;
        end
        if (b_neg_s) begin
            b_mag_s = -rt_val;
        end else begin
            b_mag_s = rt_val;
        end
    end

    // One iteration: shift-add multiply on {hi,lo}, or restoring divide with rem in hi and quotient in lo.
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_r} + {1'b0, (acc_lo_r[0] ? mcand_r : ZERO_W)};
        div_shift_s = {acc_hi_r, acc_lo_r[DATA_WIDTH-1]};
        div_diff_s  = div_shift_s - {1'b0, mcand_r};
        if (op_is_div(op_r)) begin
            if (div_diff_s[DATA_WIDTH]) begin
                next_hi_s = div_shift_s[DATA_WIDTH-1:0];
            end else begin
                next_hi_s = div_diff_s[DATA_WIDTH-1:0];
            end
            next_lo_s = {acc_lo_r[DATA_WIDTH-2:0], ~div_diff_s[DATA_WIDTH]};
        end else begin
            {next_hi_s, next_lo_s} = {mul_sum_s, acc_lo_r[DATA_WIDTH-1:1]};
        end
    end

    // Sign correction and the divide-by-zero override applied in FIX.
    always_comb begin
        neg_s  = sign_a_r ^ sign_b_r;
        prod_s = {acc_hi_r, acc_lo_r};
        if (neg_s) begin
            prod_fix_s = -prod_s;
        end else begin
            prod_fix_s = prod_s;
        end
        if (!op_is_div(op_r)) begin
            fix_hi_s = prod_fix_s[2*DATA_WIDTH-1:DATA_WIDTH];
            fix_lo_s = prod_fix_s[DATA_WIDTH-1:0];
        end else if (mcand_r == ZERO_W) begin
            fix_hi_s = rs_latched_r;
            fix_lo_s = ONES_W;
        end else begin
            fix_lo_s = neg_s ? -acc_lo_r : acc_lo_r;
            fix_hi_s = sign_a_r ? -acc_hi_r : acc_hi_r;
        end
    end

    // Control FSM with registered busy, strobes and HI/LO data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= S_IDLE;
            op_r         <= OP_MULT;
            count_r      <= CNT_ZERO;
            sign_a_r     <= 1'b0;
            sign_b_r     <= 1'b0;
            mcand_r      <= ZERO_W;
            acc_hi_r     <= ZERO_W;
            acc_lo_r     <= ZERO_W;
            rs_latched_r <= ZERO_W;
            busy_r       <= 1'b0;
            hi_en_r      <= 1'b0;
            lo_en_r      <= 1'b0;
            data_hi_r    <= ZERO_W;
            data_lo_r    <= ZERO_W;
        end else begin
            case (state_r)
                S_IDLE: begin
                    hi_en_r <= 1'b0;
                    lo_en_r <= 1'b0;
                    if (start && !cancel) begin
                        case (op)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                op_r         <= op;
                                sign_a_r     <= a_neg_s;
                                sign_b_r     <= b_neg_s;
                                rs_latched_r <= rs_val;
                                acc_hi_r     <= ZERO_W;
                                count_r      <= CNT_ZERO;
                                busy_r       <= 1'b1;
                                state_r      <= S_RUN;
                                if (op_is_div(op)) begin
                                    mcand_r  <= b_mag_s;
                                    acc_lo_r <= a_mag_s;
                                end else begin
                                    mcand_r  <= a_mag_s;
                                    acc_lo_r <= b_mag_s;
                                end
                            end
                            OP_MTHI: begin
                                data_hi_r <= rs_val;
                                hi_en_r   <= 1'b1;
                                busy_r    <= 1'b1;
                                state_r   <= S_WB;
                            end
                            OP_MTLO: begin
                                data_lo_r <= rs_val;
                                lo_en_r   <= 1'b1;
                                busy_r    <= 1'b1;
                                state_r   <= S_WB;
                            end
                            default: begin
                                state_r <= S_IDLE;
                            end
                        endcase
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (cancel) begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        acc_hi_r <= next_hi_s;
                        acc_lo_r <= next_lo_s;
                        count_r  <= count_r + 1'b1;
                        if (count_r == LAST_CNT) begin
                            state_r <= S_FIX;
                        end else begin
                            state_r <= S_RUN;
                        end
                    end
                end
                S_FIX: begin
                    if (cancel) begin
                        busy_r  <= 1'b0;
                        state_r <= S_IDLE;
                    end else begin
                        data_hi_r <= fix_hi_s;
                        data_lo_r <= fix_lo_s;
                        hi_en_r   <= 1'b1;
                        lo_en_r   <= 1'b1;
                        state_r   <= S_WB;
                    end
                end
                S_WB: begin
                    hi_en_r <= 1'b0;
                    lo_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    hi_en_r <= 1'b0;
                    lo_en_r <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign hi_en   = hi_en_r;
    assign lo_en   = lo_en_r;
    assign data_hi = data_hi_r;
    assign data_lo = data_lo_r;

endmodule

// File: tb/tb_mips_cpu_muldiv.sv
// Directed bench for mips_cpu_muldiv: vector table of full operations plus cancel/start/reset sequences.
module tb_mips_cpu_muldiv;
    import mips_cpu_pkg::*;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic        cancel  = 1'b0;
    muldiv_op_t  op      = OP_MULT;
    logic [31:0] rs_val  = 32'd0;
    logic [31:0] rt_val  = 32'd0;
    logic        busy;
    logic [31:0] data_hi;
    logic [31:0] data_lo;
    logic        hi_en;
    logic        lo_en;

    int checks   = 0;
    int failures = 0;

    mips_cpu_muldiv #(.DATA_WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op),
        .rs_val(rs_val), .rt_val(rt_val), .cancel(cancel), .busy(busy),
        .data_hi(data_hi), .data_lo(data_lo), .hi_en(hi_en), .lo_en(lo_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        muldiv_op_t  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
        logic [1:0]  en;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch in cycle 0, observe cycles 1..40; optionally pulse start+DIVU at cycle inj and cancel at cycle cc.
    task automatic run_seq(input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                           input int inj, input int cc,
                           output int scyc, output int nstr, output logic [1:0] sen,
                           output logic [31:0] fhi, output logic [31:0] flo, output logic [63:0] bmask);
        scyc = 0; nstr = 0; sen = 2'b00; bmask = 64'd0;
        op = o; rs_val = a; rt_val = b; start = 1'b1; cancel = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) tick();
            if (busy) bmask[c] = 1'b1;
            if (hi_en || lo_en) begin
                nstr++;
                if (scyc == 0) begin
                    scyc = c;
                    sen  = {hi_en, lo_en};
                end
            end
            start = (c == inj);
            if (c == inj) begin
                op = OP_DIVU; rs_val = 32'd100; rt_val = 32'd7;
            end
            cancel = (c == cc);
        end
        start = 1'b0; cancel = 1'b0;
        fhi = data_hi; flo = data_lo;
    endtask

    task automatic check_seq(input string nm, input muldiv_op_t o, input logic [31:0] a, input logic [31:0] b,
                             input int inj, input int cc, input int exp_cyc, input logic [1:0] exp_en,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int busy_last);
        int          scyc, nstr;
        logic [1:0]  sen;
        logic [31:0] fhi, flo;
        logic [63:0] bmask, exp_mask;
        run_seq(o, a, b, inj, cc, scyc, nstr, sen, fhi, flo, bmask);
        exp_mask = ((64'd1 << (busy_last + 1)) - 64'd1) & ~64'd1;
        chk({nm, "_strobe_cycle"}, 64'(scyc), 64'(exp_cyc));
        chk({nm, "_strobe_count"}, 64'(nstr), (exp_cyc != 0) ? 64'd1 : 64'd0);
        chk({nm, "_strobe_en"},    64'(sen), 64'(exp_en));
        chk({nm, "_data_hi"},      64'(fhi), 64'(exp_hi));
        chk({nm, "_data_lo"},      64'(flo), 64'(exp_lo));
        chk({nm, "_busy_cycles"},  bmask, exp_mask);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_busy, cnt_str;

        vecs[0]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 34, 2'b11};
        vecs[1]  = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 34, 2'b11};
        vecs[2]  = '{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 34, 2'b11};
        vecs[3]  = '{OP_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 34, 2'b11};
        vecs[4]  = '{OP_DIV,   32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 34, 2'b11};
        vecs[5]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 34, 2'b11};
        vecs[6]  = '{OP_MTHI,  32'h12345678, 32'h00000000, 32'h12345678, 32'h80000000,  1, 2'b10};
        vecs[7]  = '{OP_MTLO,  32'hCAFEF00D, 32'h00000000, 32'h12345678, 32'hCAFEF00D,  1, 2'b01};
        vecs[8]  = '{OP_MULT,  32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 34, 2'b11};
        vecs[9]  = '{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 34, 2'b11};
        vecs[10] = '{OP_DIVU,  32'h00000010, 32'h00000000, 32'h00000010, 32'hFFFFFFFF, 34, 2'b11};
        vecs[11] = '{OP_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 34, 2'b11};

        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",    64'(busy), 64'd0);
        chk("reset_strobes", 64'({hi_en, lo_en}), 64'd0);
        chk("reset_data_hi", 64'(data_hi), 64'd0);
        chk("reset_data_lo", 64'(data_lo), 64'd0);
        reset_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) begin
            check_seq($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0, 0,
                      vecs[i].cyc, vecs[i].en, vecs[i].hi, vecs[i].lo, vecs[i].cyc);
        end

        // start+DIVU during RUN must not re-latch: MULTU 2*3 still yields 6
        check_seq("ignored_start", OP_MULTU, 32'd2, 32'd3, 5, 0, 34, 2'b11, 32'd0, 32'd6, 34);
        // cancel in RUN after an ignored start: no write, idle from cycle 11
        check_seq("cancel_run", OP_MULT, 32'd3, 32'd5, 5, 10, 0, 2'b00, 32'd0, 32'd6, 10);
        // cancel in FIX: no write, idle from cycle 34
        check_seq("cancel_fix", OP_DIVU, 32'd100, 32'd7, 0, 33, 0, 2'b00, 32'd0, 32'd6, 33);
        // cancel in WB does not stop the MTHI write
        check_seq("cancel_wb", OP_MTHI, 32'hA5A5A5A5, 32'd0, 0, 1, 1, 2'b10, 32'hA5A5A5A5, 32'd6, 1);

        // cancel and start together in IDLE: nothing launches
        op = OP_MULTU; rs_val = 32'd9; rt_val = 32'd9; start = 1'b1; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        cnt_busy = 0; cnt_str = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy) cnt_busy++;
            if (hi_en || lo_en) cnt_str++;
            tick();
        end
        chk("idle_cancel_busy",    64'(cnt_busy), 64'd0);
        chk("idle_cancel_strobes", 64'(cnt_str), 64'd0);
        chk("idle_cancel_data_hi", 64'(data_hi), 64'hA5A5A5A5);

        // asynchronous reset in cycle 20 of a DIV clears outputs at once; no write afterwards
        op = OP_DIV; rs_val = 32'h00001000; rt_val = 32'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (19) tick();
        chk("rst_pre_busy", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_busy",    64'(busy), 64'd0);
        chk("rst_strobes", 64'({hi_en, lo_en}), 64'd0);
        chk("rst_data_hi", 64'(data_hi), 64'd0);
        chk("rst_data_lo", 64'(data_lo), 64'd0);
        tick();
        tick();
        reset_n = 1'b1;
        cnt_busy = 0; cnt_str = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (busy) cnt_busy++;
            if (hi_en || lo_en) cnt_str++;
        end
        chk("post_rst_busy",    64'(cnt_busy), 64'd0);
        chk("post_rst_strobes", 64'(cnt_str), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
